// File: rtl/servo_ramp_ctrl_if.sv
// rtl/servo_ramp_ctrl_if.sv - command/frame/status bundle between a PWM front end and servo_ramp_ctrl
//
// Signals:
//   frame_tick   one-cycle pulse at each PWM period wrap (driven by master)
//   cmd_valid    target-width command present (driven by master)
//   cmd_width    requested pulse width in clk cycles, 20 bits (driven by master)
//   cmd_ready    ramp controller can take a command (driven by slave)
//   pulse_width  registered width for the PWM comparator, 20 bits (driven by slave)
//   busy         ramp in progress (driven by slave)
//   done         one-cycle pulse when the target is reached (driven by slave)
// Modports: master = command source / PWM stage, slave = servo_ramp_ctrl.

interface servo_ramp_ctrl_if;
    logic        frame_tick;
    logic        cmd_valid;
    logic [19:0] cmd_width;
    logic        cmd_ready;
    logic [19:0] pulse_width;
    logic        busy;
    logic        done;

    modport master (
        output frame_tick,
        output cmd_valid,
        output cmd_width,
        input  cmd_ready,
        input  pulse_width,
        input  busy,
        input  done
    );

    modport slave (
        input  frame_tick,
        input  cmd_valid,
        input  cmd_width,
        output cmd_ready,
        output pulse_width,
        output busy,
        output done
    );
endinterface

// File: rtl/servo_ramp_ctrl.sv
// rtl/servo_ramp_ctrl.sv - frame-synchronous slew-limited servo pulse-width controller
//
// Ports:
//   clk    system clock, all state on its rising edge
//   rst_n  asynchronous active-low reset
//   bus    servo_ramp_ctrl_if.slave: frame_tick, cmd_valid/cmd_width/cmd_ready in,
//          pulse_width/busy/done out
// A command is taken in IDLE, its width clamped to [MIN_W, MAX_W] and latched as the
// target. In RAMP, pulse_width moves at most STEP per frame_tick toward the target and
// only on frame_tick, so the PWM stage never sees a mid-frame change.

module servo_ramp_ctrl #(
    parameter int unsigned MIN_W     = 11200,
    parameter int unsigned NEUTRAL_W = 40350,
    parameter int unsigned MAX_W     = 69500,
    parameter int unsigned STEP      = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    servo_ramp_ctrl_if.slave     bus
);

    localparam logic [19:0] MIN_V     = 20'(MIN_W);
    localparam logic [19:0] NEUTRAL_V = 20'(NEUTRAL_W);
    localparam logic [19:0] MAX_V     = 20'(MAX_W);
    localparam logic [19:0] STEP_V    = 20'(STEP);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] target_q, target_d;
    logic [19:0] width_q, width_d;
    logic        done_q, done_d;

    logic [19:0] clamped;
    logic        going_up;
    logic [19:0] distance;

    // Clamp the incoming request; target then always lies inside the legal window.
    always_comb begin
        if (bus.cmd_width < MIN_V) begin
            clamped = MIN_V;
        end else if (bus.cmd_width > MAX_V) begin
            clamped = MAX_V;
        end else begin
            clamped = bus.cmd_width;
        end
    end

    // Subtract the smaller from the larger so the distance never wraps.
    assign going_up = (target_q > width_q);
    assign distance = going_up ? (target_q - width_q) : (width_q - target_q);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        width_d  = width_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // frame_tick is ignored here; an accepted command never moves the
                // width on its own edge, even if a tick coincides.
                if (bus.cmd_valid) begin
                    target_d = clamped;
                    state_d  = RAMP;
                end
            end
            RAMP: begin
                // cmd_valid is not looked at: commands during a ramp are dropped.
                if (bus.frame_tick) begin
                    if (distance > STEP_V) begin
                        // Target is inside [MIN_W, MAX_W] and more than STEP away,
                        // so a full step cannot overshoot or leave the window.
                        width_d = going_up ? (width_q + STEP_V) : (width_q - STEP_V);
                    end else begin
                        width_d = target_q;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= NEUTRAL_V;
            width_q  <= NEUTRAL_V;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            width_q  <= width_d;
            done_q   <= done_d;
        end
    end

    // done is set on the completing RAMP edge, which can never be an accepting edge.
    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.busy        = (state_q == RAMP);
    assign bus.pulse_width = width_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// tb/tb_servo_ramp_ctrl.sv - directed self-checking bench for servo_ramp_ctrl

module tb_servo_ramp_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    servo_ramp_ctrl_if bus ();

    servo_ramp_ctrl #(
        .MIN_W     (11200),
        .NEUTRAL_W (40350),
        .MAX_W     (69500),
        .STEP      (1000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        cyc(1);
        bus.frame_tick = 1'b0;
    endtask

    task automatic send(input logic [19:0] w);
        bus.cmd_valid = 1'b1;
        bus.cmd_width = w;
        cyc(1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic chk_status(input string tag, input logic [19:0] pw, input logic rdy,
                              input logic bsy, input logic dn);
        chk({tag, "_pw"},    32'(bus.pulse_width), 32'(pw));
        chk({tag, "_ready"}, 32'(bus.cmd_ready),   32'(rdy));
        chk({tag, "_busy"},  32'(bus.busy),        32'(bsy));
        chk({tag, "_done"},  32'(bus.done),        32'(dn));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n          = 1'b0;
        bus.frame_tick = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_width  = 20'd0;

        // Reset state, held and after release
        cyc(3);
        chk_status("in_reset", 20'd40350, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc(1);
        chk_status("after_reset", 20'd40350, 1'b1, 1'b0, 1'b0);

        // frame_tick in IDLE does nothing
        tick();
        chk_status("idle_tick", 20'd40350, 1'b1, 1'b0, 1'b0);
        cyc(1);

        // Full right ramp, one tick per 100 cycles
        send(20'd69500);
        chk_status("r_accept", 20'd40350, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 29; i++) begin
            cyc(99);
            chk("r_midframe_pw", 32'(bus.pulse_width), 32'(40350 + 1000 * (i - 1)));
            tick();
            chk("r_step_pw", 32'(bus.pulse_width), 32'(40350 + 1000 * i));
            chk("r_step_done", 32'(bus.done), 32'd0);
        end
        chk("r_29_pw", 32'(bus.pulse_width), 32'd69350);
        cyc(99);
        tick();
        chk_status("r_final", 20'd69500, 1'b1, 1'b0, 1'b1);
        cyc(1);
        chk_status("r_after", 20'd69500, 1'b1, 1'b0, 1'b0);

        // Below-range command clamps to MIN_W
        do_reset();
        send(20'd5000);
        chk("l_busy", 32'(bus.busy), 32'd1);
        for (int i = 1; i <= 29; i++) begin
            cyc(20);
            tick();
            chk("l_step_pw", 32'(bus.pulse_width), 32'(40350 - 1000 * i));
            chk("l_floor", 32'(bus.pulse_width >= 20'd11200), 32'd1);
            chk("l_step_done", 32'(bus.done), 32'd0);
        end
        cyc(20);
        tick();
        chk_status("l_final", 20'd11200, 1'b1, 1'b0, 1'b1);
        cyc(1);
        chk("l_done_clear", 32'(bus.done), 32'd0);

        // Command held during a ramp is ignored, accepted only once IDLE
        do_reset();
        send(20'd69500);
        bus.cmd_valid = 1'b1;
        bus.cmd_width = 20'd11200;
        for (int i = 1; i <= 29; i++) begin
            cyc(10);
            tick();
            chk("h_step_pw", 32'(bus.pulse_width), 32'(40350 + 1000 * i));
            chk("h_busy", 32'(bus.busy), 32'd1);
        end
        cyc(10);
        tick();
        chk_status("h_final", 20'd69500, 1'b1, 1'b0, 1'b1);
        cyc(1);
        chk_status("h_accept", 20'd69500, 1'b0, 1'b1, 1'b0);
        bus.cmd_valid = 1'b0;
        cyc(5);
        tick();
        chk("h_down_pw", 32'(bus.pulse_width), 32'd68500);

        // Acceptance on a tick edge does not step
        do_reset();
        bus.cmd_valid  = 1'b1;
        bus.cmd_width  = 20'd69500;
        bus.frame_tick = 1'b1;
        cyc(1);
        bus.cmd_valid  = 1'b0;
        bus.frame_tick = 1'b0;
        chk_status("co_accept", 20'd40350, 1'b0, 1'b1, 1'b0);
        cyc(5);
        tick();
        chk("co_first_step", 32'(bus.pulse_width), 32'd41350);

        // Target equal to current width completes after exactly one tick
        do_reset();
        bus.cmd_valid  = 1'b1;
        bus.cmd_width  = 20'd40350;
        bus.frame_tick = 1'b1;
        cyc(1);
        bus.cmd_valid  = 1'b0;
        bus.frame_tick = 1'b0;
        chk_status("eq_accept", 20'd40350, 1'b0, 1'b1, 1'b0);
        cyc(5);
        tick();
        chk_status("eq_final", 20'd40350, 1'b1, 1'b0, 1'b1);
        cyc(1);
        chk("eq_done_clear", 32'(bus.done), 32'd0);

        // In-range command near the target: final partial step
        send(20'd41000);
        tick();
        chk_status("mid_final", 20'd41000, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset mid-ramp aborts without done
        do_reset();
        send(20'd69500);
        for (int i = 1; i <= 15; i++) begin
            cyc(4);
            tick();
        end
        chk("ab_pw_before", 32'(bus.pulse_width), 32'd55350);
        cyc(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_status("ab_async", 20'd40350, 1'b1, 1'b0, 1'b0);
        bus.frame_tick = 1'b1;
        cyc(1);
        bus.frame_tick = 1'b0;
        chk_status("ab_held", 20'd40350, 1'b1, 1'b0, 1'b0);

        // First edge after release accepts a command
        rst_n = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_width = 20'd11200;
        cyc(1);
        bus.cmd_valid = 1'b0;
        chk_status("post_rst_accept", 20'd40350, 1'b0, 1'b1, 1'b0);
        cyc(1);
        chk("post_rst_no_done", 32'(bus.done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
